// File: rtl/uncache_axi_bridge_pkg.sv
// rtl/uncache_axi_bridge_pkg.sv - state encoding and AXI constants for the uncache AXI bridge
package uncache_axi_bridge_pkg;

    typedef enum logic [5:0] {
        ST_IDLE = 6'b000001,
        ST_AR   = 6'b000010,
        ST_R    = 6'b000100,
        ST_AW_W = 6'b001000,
        ST_B    = 6'b010000,
        ST_DONE = 6'b100000
    } state_t;

    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/uncache_axi_bridge.sv
// rtl/uncache_axi_bridge.sv - single-word uncached request to AXI4 single-beat bridge
// Optional error capture ports: UNCACHE_AXI_ERR_CAPTURE_EN
module uncache_axi_bridge
    import uncache_axi_bridge_pkg::*;
#(
    parameter int               ID_WD  = 4,
    parameter logic [ID_WD-1:0] AXI_ID = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             axi_en,
    input  logic [3:0]       axi_wsel,
    input  logic [31:0]      axi_addr,
    input  logic [31:0]      axi_wdata,
    output logic             reload,
    output logic [31:0]      axi_rdata,
    output logic [ID_WD-1:0] arid,
    output logic [31:0]      araddr,
    output logic [7:0]       arlen,
    output logic [2:0]       arsize,
    output logic [1:0]       arburst,
    output logic             arvalid,
    input  logic             arready,
    input  logic [ID_WD-1:0] rid,
    input  logic [31:0]      rdata,
    input  logic [1:0]       rresp,
    input  logic             rlast,
    input  logic             rvalid,
    output logic             rready,
    output logic [ID_WD-1:0] awid,
    output logic [31:0]      awaddr,
    output logic [7:0]       awlen,
    output logic [2:0]       awsize,
    output logic [1:0]       awburst,
    output logic             awvalid,
    input  logic             awready,
    output logic [31:0]      wdata,
    output logic [3:0]       wstrb,
    output logic             wlast,
    output logic             wvalid,
    input  logic             wready,
    input  logic [ID_WD-1:0] bid,
    input  logic [1:0]       bresp,
    input  logic             bvalid,
    output logic             bready
`ifdef UNCACHE_AXI_ERR_CAPTURE_EN
    ,
    output logic             err_valid,
    output logic [31:0]      err_addr,
    output logic             err_is_wr,
    input  logic             err_clr
`endif
);

    state_t      r_state;
    logic        r_arvalid, r_rready, r_awvalid, r_wvalid, r_bready, r_reload;
    logic        r_aw_done, r_w_done;
    logic [31:0] r_araddr, r_awaddr, r_wdata, r_rdata;
    logic [3:0]  r_wstrb;

    logic w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs, w_aw_fin, w_w_fin;

    assign w_ar_hs  = r_arvalid & arready;
    assign w_r_hs   = r_rready & rvalid;
    assign w_aw_hs  = r_awvalid & awready;
    assign w_w_hs   = r_wvalid & wready;
    assign w_b_hs   = r_bready & bvalid;
    // A channel counts as finished if it completed earlier or completes this cycle
    assign w_aw_fin = r_aw_done | w_aw_hs;
    assign w_w_fin  = r_w_done | w_w_hs;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_reload  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_araddr  <= '0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdata   <= '0;
        end else begin
            r_reload <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (axi_en) begin
                        if (axi_wsel == 4'b0000) begin
                            r_araddr  <= axi_addr;
                            r_arvalid <= 1'b1;
                            r_state   <= ST_AR;
                        end else begin
                            r_awaddr  <= axi_addr;
                            r_wdata   <= axi_wdata;
                            r_wstrb   <= axi_wsel;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                            r_state   <= ST_AW_W;
                        end
                    end
                end
                ST_AR: begin
                    if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_R;
                    end
                end
                ST_R: begin
                    if (w_r_hs) begin
                        r_rdata  <= rdata;
                        r_rready <= 1'b0;
                        r_reload <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                end
                ST_AW_W: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_fin && w_w_fin) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_B;
                    end
                end
                ST_B: begin
                    if (w_b_hs) begin
                        r_bready <= 1'b0;
                        r_reload <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign reload    = r_reload;
    assign axi_rdata = r_rdata;
    assign arid      = AXI_ID;
    assign araddr    = r_araddr;
    assign arlen     = AXI_LEN_SINGLE;
    assign arsize    = AXI_SIZE_WORD;
    assign arburst   = AXI_BURST_INCR;
    assign arvalid   = r_arvalid;
    assign rready    = r_rready;
    assign awid      = AXI_ID;
    assign awaddr    = r_awaddr;
    assign awlen     = AXI_LEN_SINGLE;
    assign awsize    = AXI_SIZE_WORD;
    assign awburst   = AXI_BURST_INCR;
    assign awvalid   = r_awvalid;
    assign wdata     = r_wdata;
    assign wstrb     = r_wstrb;
    assign wlast     = 1'b1;
    assign wvalid    = r_wvalid;
    assign bready    = r_bready;

`ifdef UNCACHE_AXI_ERR_CAPTURE_EN
    logic        r_err_valid, r_err_is_wr;
    logic [31:0] r_err_addr;
    logic        w_err_hit;

    assign w_err_hit = (w_r_hs && (rresp != AXI_RESP_OKAY)) ||
                       (w_b_hs && (bresp != AXI_RESP_OKAY));

    // First error is sticky; a clear in the same cycle as a new error lets the new one in
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_valid <= 1'b0;
            r_err_is_wr <= 1'b0;
            r_err_addr  <= '0;
        end else if (w_err_hit && (!r_err_valid || err_clr)) begin
            r_err_valid <= 1'b1;
            r_err_is_wr <= w_b_hs;
            r_err_addr  <= w_b_hs ? r_awaddr : r_araddr;
        end else if (err_clr) begin
            r_err_valid <= 1'b0;
        end
    end

    assign err_valid = r_err_valid;
    assign err_addr  = r_err_addr;
    assign err_is_wr = r_err_is_wr;

    logic w_unused;
    assign w_unused = ^{rid, rlast, bid};
`else
    logic w_unused;
    assign w_unused = ^{rid, rlast, bid, rresp, bresp};
`endif

endmodule

// File: tb/tb_uncache_axi_bridge.sv
// tb/tb_uncache_axi_bridge.sv - self-checking bench for uncache_axi_bridge
module tb_uncache_axi_bridge;
    localparam int ID_WD = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             axi_en;
    logic [3:0]       axi_wsel;
    logic [31:0]      axi_addr, axi_wdata;
    logic             reload;
    logic [31:0]      axi_rdata;
    logic [ID_WD-1:0] arid, rid, awid, bid;
    logic [31:0]      araddr, rdata, awaddr, wdata;
    logic [7:0]       arlen, awlen;
    logic [2:0]       arsize, awsize;
    logic [1:0]       arburst, awburst, rresp, bresp;
    logic             arvalid, arready, rlast, rvalid, rready;
    logic             awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]       wstrb;
`ifdef UNCACHE_AXI_ERR_CAPTURE_EN
    logic             err_valid, err_is_wr, err_clr;
    logic [31:0]      err_addr;
`endif

    uncache_axi_bridge #(.ID_WD(ID_WD), .AXI_ID(4'd0)) dut (
        .clk(clk), .rst(rst), .axi_en(axi_en), .axi_wsel(axi_wsel),
        .axi_addr(axi_addr), .axi_wdata(axi_wdata), .reload(reload), .axi_rdata(axi_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
`ifdef UNCACHE_AXI_ERR_CAPTURE_EN
        , .err_valid(err_valid), .err_addr(err_addr), .err_is_wr(err_is_wr), .err_clr(err_clr)
`endif
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] model_rdata;

    typedef struct {
        logic [3:0]  wsel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          ar_w, r_w, aw_w, w_w, b_w;
        int          exp_lat;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_lat(input vec_t v);
        if (v.wsel == 4'd0) return 3 + v.ar_w + v.r_w;
        return 3 + ((v.aw_w > v.w_w) ? v.aw_w : v.w_w) + v.b_w;
    endfunction

    function automatic vec_t mk(input logic [3:0] ws, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rd, input logic [1:0] rs, input int arw,
                                input int rw, input int aww, input int ww, input int bw, input int lat);
        vec_t v;
        v.wsel = ws; v.addr = a; v.wdata = wd; v.rdata = rd; v.resp = rs;
        v.ar_w = arw; v.r_w = rw; v.aw_w = aww; v.w_w = ww; v.b_w = bw; v.exp_lat = lat;
        return v;
    endfunction

    task automatic slave_idle();
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_outputs", {26'd0, arvalid, rready, awvalid, wvalid, bready, reload}, 32'd0);
            step();
        end
    endtask

    // Drives one request and a slave with the given per-channel delays, checking every cycle
    task automatic run_txn(input vec_t v);
        logic        wr;
        int          rs, bs;
        logic [31:0] exp_rd;
        wr     = (v.wsel != 4'd0);
        rs     = 2 + v.ar_w;
        bs     = 2 + ((v.aw_w > v.w_w) ? v.aw_w : v.w_w);
        exp_rd = wr ? model_rdata : v.rdata;
        axi_en = 1'b1; axi_wsel = v.wsel; axi_addr = v.addr; axi_wdata = v.wdata;
        for (int c = 0; c <= v.exp_lat; c++) begin
            if (c > 0) begin
                axi_addr  = $urandom;
                axi_wdata = $urandom;
            end
            arready = !wr && (c == 1 + v.ar_w);
            rvalid  = !wr && (c == rs + v.r_w);
            rdata   = rvalid ? v.rdata : $urandom;
            rresp   = v.resp;
            awready = wr && (c == 1 + v.aw_w);
            wready  = wr && (c == 1 + v.w_w);
            bvalid  = wr && (c == bs + v.b_w);
            bresp   = v.resp;
            @(negedge clk);
            chk("arvalid", arvalid, !wr && c >= 1 && c <= 1 + v.ar_w);
            chk("rready", rready, !wr && c >= rs && c <= rs + v.r_w);
            chk("awvalid", awvalid, wr && c >= 1 && c <= 1 + v.aw_w);
            chk("wvalid", wvalid, wr && c >= 1 && c <= 1 + v.w_w);
            chk("bready", bready, wr && c >= bs && c <= bs + v.b_w);
            chk("reload", reload, c == v.exp_lat);
            if (arvalid) chk("araddr", araddr, v.addr);
            if (awvalid) chk("awaddr", awaddr, v.addr);
            if (wvalid) begin
                chk("wdata", wdata, v.wdata);
                chk("wstrb", wstrb, v.wsel);
            end
            if (reload) chk("axi_rdata", axi_rdata, exp_rd);
            step();
        end
        model_rdata = exp_rd;
        axi_en = 1'b0;
        slave_idle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        vec_t v;
        rst = 1'b1; axi_en = 1'b0; axi_wsel = '0; axi_addr = '0; axi_wdata = '0;
        rid = '0; bid = '0; rlast = 1'b1;
        slave_idle();
`ifdef UNCACHE_AXI_ERR_CAPTURE_EN
        err_clr = 1'b0;
`endif
        model_rdata = 32'd0;

        tbl[0] = mk(4'h0, 32'h1FD0_F000, 32'h0, 32'h1234_5678, 2'b00, 0, 0, 0, 0, 0, 3);
        tbl[1] = mk(4'h3, 32'hBFAF_8000, 32'hAABB_CCDD, 32'h0, 2'b00, 0, 0, 2, 0, 3, 8);
        tbl[2] = mk(4'h0, 32'h0000_1234, 32'h0, 32'hCAFE_F00D, 2'b00, 5, 1, 0, 0, 0, 9);
        tbl[3] = mk(4'hF, 32'h1FD0_0008, 32'h0102_0304, 32'h0, 2'b00, 0, 0, 0, 3, 0, 6);
        tbl[4] = mk(4'h0, 32'h1FD0_0004, 32'h0, 32'h0BAD_BEEF, 2'b00, 0, 2, 0, 0, 0, 5);

        step();
        step();
        @(negedge clk);
        chk("rst_handshakes", {26'd0, arvalid, rready, awvalid, wvalid, bready, reload}, 32'd0);
        chk("rst_axi_rdata", axi_rdata, 32'd0);
        chk("rst_araddr", araddr, 32'd0);
        chk("rst_awaddr", awaddr, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_wstrb", wstrb, 32'd0);
        chk("const_len", {arlen, awlen}, 32'd0);
        chk("const_size", {arsize, awsize}, {26'd0, 3'b010, 3'b010});
        chk("const_burst", {arburst, awburst}, {28'd0, 2'b01, 2'b01});
        chk("const_wlast", wlast, 32'd1);
        chk("const_id", {arid, awid}, 32'd0);
`ifdef UNCACHE_AXI_ERR_CAPTURE_EN
        chk("rst_err_valid", err_valid, 32'd0);
`endif
        step();
        rst = 1'b0;
        idle_cycles(1);

        // Vector table applied back-to-back: each request follows the previous reload directly
        for (int i = 0; i < 5; i++) begin
            chk("table_lat_model", model_lat(tbl[i]), tbl[i].exp_lat);
            run_txn(tbl[i]);
        end
        idle_cycles(2);

        // Reset while waiting in R
        axi_en = 1'b1; axi_wsel = 4'h0; axi_addr = 32'h1FD0_0100;
        step();
        arready = 1'b1;
        step();
        arready = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("pre_rst_rready", rready, 32'd1);
        step();
        rst = 1'b0; axi_en = 1'b0;
        @(negedge clk);
        chk("midrst_handshakes", {26'd0, arvalid, rready, awvalid, wvalid, bready, reload}, 32'd0);
        chk("midrst_axi_rdata", axi_rdata, 32'd0);
        chk("midrst_araddr", araddr, 32'd0);
        model_rdata = 32'd0;
        step();
        idle_cycles(1);

        for (int i = 0; i < 30; i++) begin
            v.wsel  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            v.addr  = $urandom;
            v.wdata = $urandom;
            v.rdata = $urandom;
            v.resp  = 2'($urandom_range(0, 3));
            v.ar_w  = $urandom_range(0, 3);
            v.r_w   = $urandom_range(0, 3);
            v.aw_w  = $urandom_range(0, 3);
            v.w_w   = $urandom_range(0, 3);
            v.b_w   = $urandom_range(0, 3);
            v.exp_lat = model_lat(v);
            run_txn(v);
            idle_cycles($urandom_range(0, 2));
        end

`ifdef UNCACHE_AXI_ERR_CAPTURE_EN
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        @(negedge clk);
        chk("err_cleared0", err_valid, 32'd0);
        step();
        run_txn(mk(4'h1, 32'h1FE0_0000, 32'h5555_AAAA, 32'h0, 2'b10, 0, 0, 1, 0, 1, 5));
        @(negedge clk);
        chk("err_valid", err_valid, 32'd1);
        chk("err_addr", err_addr, 32'h1FE0_0000);
        chk("err_is_wr", err_is_wr, 32'd1);
        step();
        run_txn(mk(4'h0, 32'h0000_0040, 32'h0, 32'h7777_0000, 2'b11, 0, 0, 0, 0, 0, 3));
        @(negedge clk);
        chk("err_sticky_addr", err_addr, 32'h1FE0_0000);
        chk("err_sticky_wr", err_is_wr, 32'd1);
        step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        @(negedge clk);
        chk("err_clr", err_valid, 32'd0);
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
